// File: rtl/mem_data_resp.sv
// Word-addressed data memory with a fixed request-to-response latency.
// Single outstanding access; the response is a one-cycle ready strobe qualified by err.
module mem_data_resp #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] address,
  input  logic [31:0] W_data,
  output logic [31:0] R_data,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_next;

  logic          r_wr;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic          r_err;

  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_idle;
  logic          w_accept;
  logic          w_cur_wr;
  logic [31:0]   w_cur_addr;
  logic [31:0]   w_cur_wdata;
  logic          w_cur_valid;
  logic [AW-1:0] w_cur_idx;
  logic          w_enter_resp;
  logic          w_mem_we;

  assign w_idle   = (r_state == IDLE);
  assign w_accept = w_idle && req;

  // With LATENCY=1 the RESP entry edge is the capture edge, so the live inputs are used there.
  assign w_cur_wr    = w_idle ? wr     : r_wr;
  assign w_cur_addr  = w_idle ? address : r_addr;
  assign w_cur_wdata = w_idle ? W_data : r_wdata;

  assign w_cur_valid = (w_cur_addr[1:0] == 2'b00) && (w_cur_addr[31:2] < 30'(DEPTH_WORDS));
  assign w_cur_idx   = w_cur_addr[AW+1:2];

  assign w_enter_resp = (w_state_next == RESP) && (r_state != RESP);
  assign w_mem_we     = w_enter_resp && w_cur_valid && w_cur_wr;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (req) begin
          w_cnt_next   = CNT_LOAD;
          w_state_next = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        // Counter hits zero on the same edge that registers RESP.
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_next = RESP;
        end
      end
      RESP: begin
        w_cnt_next   = 4'd0;
        w_state_next = IDLE;
      end
      default: begin
        w_cnt_next   = 4'd0;
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_wr    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_wr    <= wr;
        r_addr  <= address;
        r_wdata <= W_data;
      end
      if (w_enter_resp) begin
        r_err   <= !w_cur_valid;
        r_rdata <= (w_cur_valid && !w_cur_wr) ? r_mem[w_cur_idx] : 32'd0;
      end else if (r_state == RESP) begin
        r_err   <= 1'b0;
        r_rdata <= 32'd0;
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_cur_idx] <= w_cur_wdata;
    end
  end

  assign ready  = (r_state == RESP);
  assign busy   = (r_state != IDLE);
  assign err    = ready && r_err;
  assign R_data = ready ? r_rdata : 32'd0;

endmodule

// File: tb/tb_mem_data_resp.sv
// Directed bench for mem_data_resp: three instances (L2/D64, L1/D64, L15/D1024)
// driven from a vector table plus hand-written hold-request and reset sequences.
module tb_mem_data_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [2:0]       req_v;
  logic             wr;
  logic [31:0]      address;
  logic [31:0]      W_data;
  logic [2:0][31:0] rd_v;
  logic [2:0]       rdy_v;
  logic [2:0]       err_v;
  logic [2:0]       busy_v;

  int n_cmp  = 0;
  int n_fail = 0;
  int lat_of [3] = '{2, 1, 15};

  mem_data_resp #(.DEPTH_WORDS(64), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .req(req_v[0]), .wr(wr), .address(address), .W_data(W_data),
    .R_data(rd_v[0]), .ready(rdy_v[0]), .err(err_v[0]), .busy(busy_v[0])
  );

  mem_data_resp #(.DEPTH_WORDS(64), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .req(req_v[1]), .wr(wr), .address(address), .W_data(W_data),
    .R_data(rd_v[1]), .ready(rdy_v[1]), .err(err_v[1]), .busy(busy_v[1])
  );

  mem_data_resp #(.DEPTH_WORDS(1024), .LATENCY(15)) u_l15 (
    .clk(clk), .reset(reset), .req(req_v[2]), .wr(wr), .address(address), .W_data(W_data),
    .R_data(rd_v[2]), .ready(rdy_v[2]), .err(err_v[2]), .busy(busy_v[2])
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the cycle after the ready cycle.
  task automatic xact(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic e_err, input logic [31:0] e_rd, input string nm);
    int cyc;
    req_v    = '0;
    req_v[d] = 1'b1;
    wr       = w;
    address  = a;
    W_data   = wd;
    @(negedge clk);
    req_v   = '0;
    wr      = ~w;
    address = 32'hFFFF_FFF3;
    W_data  = ~wd;
    check({nm, " busy after accept"}, 32'(busy_v[d]), 32'd1);
    cyc = 1;
    while (!rdy_v[d] && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({nm, " latency"}, cyc, lat_of[d]);
    check({nm, " busy in ready"}, 32'(busy_v[d]), 32'd1);
    check({nm, " err"}, 32'(err_v[d]), 32'(e_err));
    check({nm, " R_data"}, rd_v[d], e_rd);
    @(negedge clk);
    check({nm, " idle after"}, {29'd0, busy_v[d], rdy_v[d], err_v[d]}, 32'd0);
    check({nm, " R_data idle"}, rd_v[d], 32'd0);
  endtask

  typedef struct {
    int          dut;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        e_err;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs [$];

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] hold_addr [9];
    logic [31:0] hold_exp  [3];
    int          seen;

    vecs.push_back('{0, 1'b1, 32'h10,   32'hDEADBEEF, 1'b0, 32'h0});
    vecs.push_back('{0, 1'b0, 32'h10,   32'h0,        1'b0, 32'hDEADBEEF});
    vecs.push_back('{0, 1'b1, 32'h8,    32'h11112222, 1'b0, 32'h0});
    vecs.push_back('{0, 1'b1, 32'h0,    32'h0BADF00D, 1'b0, 32'h0});
    vecs.push_back('{0, 1'b1, 32'h4,    32'h44444444, 1'b0, 32'h0});
    vecs.push_back('{0, 1'b0, 32'h13,   32'h0,        1'b1, 32'h0});
    vecs.push_back('{0, 1'b0, 32'h100,  32'h0,        1'b1, 32'h0});
    vecs.push_back('{0, 1'b1, 32'h100,  32'hFFFFFFFF, 1'b1, 32'h0});
    vecs.push_back('{0, 1'b0, 32'h0,    32'h0,        1'b0, 32'h0BADF00D});
    vecs.push_back('{0, 1'b1, 32'hFC,   32'hCAFEF00D, 1'b0, 32'h0});
    vecs.push_back('{0, 1'b0, 32'hFC,   32'h0,        1'b0, 32'hCAFEF00D});
    vecs.push_back('{0, 1'b0, 32'h103,  32'h0,        1'b1, 32'h0});
    vecs.push_back('{1, 1'b1, 32'h4,    32'h12345678, 1'b0, 32'h0});
    vecs.push_back('{1, 1'b0, 32'h4,    32'h0,        1'b0, 32'h12345678});
    vecs.push_back('{1, 1'b0, 32'h2,    32'h0,        1'b1, 32'h0});
    vecs.push_back('{2, 1'b1, 32'hFFC,  32'h5A5AA5A5, 1'b0, 32'h0});
    vecs.push_back('{2, 1'b0, 32'hFFC,  32'h0,        1'b0, 32'h5A5AA5A5});
    vecs.push_back('{2, 1'b0, 32'h1000, 32'h0,        1'b1, 32'h0});

    hold_addr = '{32'h0, 32'h13, 32'h100, 32'h4, 32'h13, 32'h100, 32'h8, 32'h13, 32'h100};
    hold_exp  = '{32'h0BADF00D, 32'h44444444, 32'h11112222};

    reset   = 1'b0;
    req_v   = '0;
    wr      = 1'b0;
    address = 32'h0;
    W_data  = 32'h0;
    #3;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset dut%0d ready", d), 32'(rdy_v[d]), 32'd0);
      check($sformatf("reset dut%0d busy", d), 32'(busy_v[d]), 32'd0);
      check($sformatf("reset dut%0d err", d), 32'(err_v[d]), 32'd0);
      check($sformatf("reset dut%0d R_data", d), rd_v[d], 32'd0);
    end

    // Release reset and present the first request for the very next edge.
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      xact(vecs[i].dut, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].e_err, vecs[i].e_rd,
           $sformatf("vec%0d", i));
    end

    // req held high with a new address every cycle; only IDLE-cycle addresses are taken.
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) begin
        check($sformatf("hold c%0d ready", c), 32'(rdy_v[0]), 32'((c % 3) == 2));
        check($sformatf("hold c%0d busy", c), 32'(busy_v[0]), 32'((c % 3) != 0));
        if ((c % 3) == 2) begin
          check($sformatf("hold c%0d R_data", c), rd_v[0], hold_exp[c / 3]);
          check($sformatf("hold c%0d err", c), 32'(err_v[0]), 32'd0);
        end
      end
      wr = 1'b0;
      if (c < 9) begin
        req_v[0] = 1'b1;
        address  = hold_addr[c];
      end else begin
        req_v[0] = 1'b0;
      end
      @(negedge clk);
    end

    // Reset during WAIT aborts the write.
    req_v[0] = 1'b1;
    wr       = 1'b1;
    address  = 32'h8;
    W_data   = 32'hAAAA5555;
    @(negedge clk);
    req_v = '0;
    check("rstwait busy before", 32'(busy_v[0]), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rstwait async busy", 32'(busy_v[0]), 32'd0);
    check("rstwait async ready", 32'(rdy_v[0]), 32'd0);
    check("rstwait async err", 32'(err_v[0]), 32'd0);
    check("rstwait async R_data", rd_v[0], 32'd0);
    @(negedge clk);
    reset = 1'b1;
    seen  = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      seen += int'(rdy_v[0]);
    end
    check("rstwait no ready", seen, 0);
    xact(0, 1'b0, 32'h8, 32'h0, 1'b0, 32'h11112222, "rstwait readback");

    // Reset in the RESP cycle drops ready but keeps the committed write.
    req_v[0] = 1'b1;
    wr       = 1'b1;
    address  = 32'h4;
    W_data   = 32'h77778888;
    @(negedge clk);
    req_v = '0;
    @(negedge clk);
    check("rstresp ready before", 32'(rdy_v[0]), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rstresp async ready", 32'(rdy_v[0]), 32'd0);
    check("rstresp async busy", 32'(busy_v[0]), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    xact(0, 1'b0, 32'h4, 32'h0, 1'b0, 32'h77778888, "rstresp readback");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_data_resp.md
MEM_DATA_RESP -- requirements
Module: mem_data_resp

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, number of 32-bit words stored (power of two, 16..1024).
REQ-002 Parameter LATENCY, default 2, cycles from accepted request to response (legal range 1..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req  input  1  initiator requests an access; sampled only in IDLE.
REQ-006 wr  input  1  1 = write, 0 = read; sampled with req.
REQ-007 address  input  32  byte address from the ALU result; word index = address[31:2].
REQ-008 W_data  input  32  store data; sampled with req.
REQ-009 R_data  output  32  load data; valid only while ready=1.
REQ-010 ready  output  1  one-cycle response strobe ending every accepted request.
REQ-011 err  output  1  qualifies ready; 1 = request rejected (misaligned or out of range).
REQ-012 busy  output  1  1 from acceptance until the ready cycle inclusive.

Function
REQ-013 States: IDLE, WAIT, RESP; no other reachable state.
REQ-014 IDLE with req=1 at edge k: capture wr, address, W_data into internal registers; counter loads LATENCY-1; go to WAIT, or go directly to RESP if LATENCY=1.
REQ-015 WAIT: counter decrements each cycle; at counter=0 the next state is RESP.
REQ-016 ready=1 exactly during cycle k+LATENCY (after edge k+LATENCY-1 has registered RESP); RESP always returns to IDLE on the following edge.
REQ-017 busy=1 in WAIT and RESP; busy=0 in IDLE.
REQ-018 req while busy=1 is ignored: no capture, no queueing, no error.
REQ-019 A new request in the cycle after RESP (back in IDLE) is accepted; maximum throughput is one access per LATENCY+1 cycles.
REQ-020 Request is invalid if address[1:0]!=0 or address[31:2]>=DEPTH_WORDS; an invalid request follows the same timing with err=1, R_data=0, and no array write.
REQ-021 Valid write: the array word is updated on the edge that enters RESP; R_data=0 during its ready cycle.
REQ-022 Valid read: R_data = word content at the time RESP is entered; R_data=0 whenever ready=0.
REQ-023 err=0 whenever ready=0.
REQ-024 Inputs changing after the capture edge do not affect the response in progress.
REQ-025 Read of a word written by the immediately preceding transaction returns the new data.
REQ-026 Array contents are uninitialised after power-up and are not cleared by reset.

Reset
REQ-027 reset=0 forces immediately (asynchronously): state IDLE, counter 0, ready=0, err=0, busy=0, R_data=0, captured registers 0.
REQ-028 reset asserted in WAIT aborts the transaction: no write is committed and no ready is produced.
REQ-029 reset asserted in the RESP cycle clears ready in the same cycle; the array write already committed on RESP entry is retained.
REQ-030 First request is accepted on the first rising edge at which reset=1 and req=1.

Verification
REQ-031 LATENCY=2: write 0xDEADBEEF to 0x10 (req at edge 0) -> busy=1 after edge 0, ready=1/err=0 after edge 1, busy=0 after edge 2; then read 0x10 -> R_data=0xDEADBEEF with ready.
REQ-032 Read 0x13 (misaligned) and 0x100 with DEPTH_WORDS=64 -> ready with err=1, R_data=0; a later read of word 0x100>>2 mod 64 is unchanged.
REQ-033 Hold req=1 continuously with distinct addresses 0x0,0x4,0x8 -> accepted only at IDLE edges, exactly one ready per LATENCY+1 cycles, and addresses changed while busy are ignored.
REQ-034 LATENCY=1 back-to-back write 0x4=0x12345678 then read 0x4 -> read returns 0x12345678 (REQ-025).
REQ-035 Write 0x8=0xAAAA5555 with reset pulsed low in WAIT -> all outputs 0 asynchronously, no ready; subsequent read 0x8 returns the prior content, not 0xAAAA5555.
REQ-036 LATENCY=15, DEPTH_WORDS=1024: write/read last word 0xFFC -> ready exactly 15 cycles after acceptance, data matches.
